// File: rtl/memory_stage.sv
// Memory stage of the RISC pipeline: performs loads/stores over a single-outstanding
// data-memory port and registers the result into the MEM/WB output and memory bypass.
module memory_stage #(
  parameter int         ADDR_WIDTH    = 32,
  parameter logic [3:0] EX_MISALIGNED = 4'd4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uValid,
  output logic                  uStall,
  output logic                  dValid,
  input  logic                  dStall,
  input  logic [3:0]            uopInEx,
  input  logic                  uopInExValid,
  input  logic [4:0]            uopInRd,
  input  logic [31:0]           uopInRdVal,
  input  logic [31:0]           uopInRs2Val,
  input  logic                  uopInIsLd,
  input  logic                  uopInIsSt,
  input  logic [1:0]            uopInSize,
  input  logic                  uopInIsUnsigned,
  input  logic [3:0]            uopInFlags,
  input  logic                  uopInFlagsValid,
  output logic [3:0]            uopOutEx,
  output logic                  uopOutExValid,
  output logic [4:0]            uopOutRd,
  output logic [31:0]           uopOutRdVal,
  output logic [3:0]            uopOutFlags,
  output logic                  uopOutFlagsValid,
  output logic                  uopOutIsSt,
  output logic [4:0]            memBypassR,
  output logic [31:0]           memBypassRVal,
  output logic                  memBypassRValid,
  output logic [3:0]            memBypassFlags,
  output logic                  memBypassFlagsValid,
  output logic                  dmemReqValid,
  input  logic                  dmemReqReady,
  output logic [ADDR_WIDTH-1:0] dmemReqAddr,
  output logic                  dmemReqWe,
  output logic [3:0]            dmemReqWstrb,
  output logic [31:0]           dmemReqWdata,
  input  logic                  dmemRspValid,
  input  logic [31:0]           dmemRspData
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic [3:0]  ex;
    logic        exValid;
    logic [4:0]  rd;
    logic [31:0] rdVal;
    logic [31:0] rs2Val;
    logic        isLd;
    logic        isSt;
    logic [1:0]  size;
    logic        isUnsigned;
    logic [3:0]  flags;
    logic        flagsValid;
  } uop_t;

  state_t      state;
  uop_t        inUop;
  uop_t        holdUop;
  logic        accept;
  logic        inIsMem;
  logic        inMisaligned;
  logic        inNeedsReq;
  logic [31:0] reqAddrVal;
  logic [31:0] reqData;
  logic        reqIsLd;
  logic [1:0]  reqSize;
  logic [1:0]  reqLane;
  logic [31:0] laneData;
  logic [31:0] loadData;
  logic        complete;
  logic [3:0]  doneEx;
  logic        doneExValid;
  logic [4:0]  doneRd;
  logic [31:0] doneRdVal;
  logic [3:0]  doneFlags;
  logic        doneFlagsValid;
  logic        doneIsSt;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

  assign inUop = {uopInEx, uopInExValid, uopInRd, uopInRdVal, uopInRs2Val, uopInIsLd,
                  uopInIsSt, uopInSize, uopInIsUnsigned, uopInFlags, uopInFlagsValid};

  assign uStall       = (state != IDLE) || (dValid && dStall);
  assign accept       = uValid && !uStall;
  assign inIsMem      = (inUop.isLd || inUop.isSt) && !inUop.exValid;
  assign inMisaligned = misaligned(inUop.size, inUop.rdVal[1:0]);
  assign inNeedsReq   = inIsMem && !inMisaligned;

  // Request comes straight from the input in the accept cycle, then from the hold register
  // so the fields stay stable however long the memory takes to accept.
  always_comb begin
    reqAddrVal = inUop.rdVal;
    reqData    = inUop.rs2Val;
    reqIsLd    = inUop.isLd;
    reqSize    = inUop.size;
    if (state == REQ) begin
      reqAddrVal = holdUop.rdVal;
      reqData    = holdUop.rs2Val;
      reqIsLd    = holdUop.isLd;
      reqSize    = holdUop.size;
    end
    reqLane      = reqAddrVal[1:0];
    dmemReqValid = rst && ((state == REQ) || (state == IDLE && accept && inNeedsReq));
    dmemReqAddr  = {reqAddrVal[ADDR_WIDTH-1:2], 2'b00};
    dmemReqWe    = !reqIsLd;
    case (reqSize)
      2'd0: begin
        dmemReqWdata = {4{reqData[7:0]}};
        dmemReqWstrb = 4'b0001 << reqLane;
      end
      2'd1: begin
        dmemReqWdata = {2{reqData[15:0]}};
        dmemReqWstrb = 4'b0011 << reqLane;
      end
      default: begin
        dmemReqWdata = reqData;
        dmemReqWstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    laneData = dmemRspData >> {holdUop.rdVal[1:0], 3'b000};
    case (holdUop.size)
      2'd0:    loadData = holdUop.isUnsigned ? {24'b0, laneData[7:0]}
                                             : {{24{laneData[7]}}, laneData[7:0]};
      2'd1:    loadData = holdUop.isUnsigned ? {16'b0, laneData[15:0]}
                                             : {{16{laneData[15]}}, laneData[15:0]};
      default: loadData = laneData;
    endcase
  end

  // Decide whether a uop retires at the coming edge and what it writes to the output.
  always_comb begin
    complete       = 1'b0;
    doneEx         = holdUop.ex;
    doneExValid    = holdUop.exValid;
    doneRd         = holdUop.rd;
    doneRdVal      = holdUop.rdVal;
    doneFlags      = holdUop.flags;
    doneFlagsValid = holdUop.flagsValid;
    doneIsSt       = holdUop.isSt;
    case (state)
      IDLE: begin
        doneEx         = inUop.ex;
        doneExValid    = inUop.exValid;
        doneRd         = inUop.rd;
        doneRdVal      = inUop.rdVal;
        doneFlags      = inUop.flags;
        doneFlagsValid = inUop.flagsValid;
        doneIsSt       = inUop.isSt;
        if (accept) begin
          if (!inIsMem) begin
            complete = 1'b1;
          end else if (inMisaligned) begin
            complete    = 1'b1;
            doneEx      = EX_MISALIGNED;
            doneExValid = 1'b1;
          end else if (!inUop.isLd && dmemReqReady) begin
            complete = 1'b1;
          end
        end
      end
      REQ:  complete = dmemReqReady && !holdUop.isLd;
      WAIT: begin
        complete  = dmemRspValid;
        doneRdVal = loadData;
      end
      default: complete = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      holdUop          <= '0;
      dValid           <= 1'b0;
      uopOutEx         <= '0;
      uopOutExValid    <= 1'b0;
      uopOutRd         <= '0;
      uopOutRdVal      <= '0;
      uopOutFlags      <= '0;
      uopOutFlagsValid <= 1'b0;
      uopOutIsSt       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            holdUop <= inUop;
            if (inNeedsReq) begin
              if (!dmemReqReady)    state <= REQ;
              else if (inUop.isLd)  state <= WAIT;
            end
          end
        end
        REQ:     if (dmemReqReady) state <= holdUop.isLd ? WAIT : IDLE;
        WAIT:    if (dmemRspValid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (!(dValid && dStall)) begin
        dValid <= complete;
        if (complete) begin
          uopOutEx         <= doneEx;
          uopOutExValid    <= doneExValid;
          uopOutRd         <= doneRd;
          uopOutRdVal      <= doneRdVal;
          uopOutFlags      <= doneFlags;
          uopOutFlagsValid <= doneFlagsValid;
          uopOutIsSt       <= doneIsSt;
        end
      end
    end
  end

  // Stores and faulted uops never forward a register value to execute.
  assign memBypassR          = uopOutRd;
  assign memBypassRVal       = uopOutRdVal;
  assign memBypassRValid     = dValid && (uopOutRd != 5'd0) && !uopOutExValid && !uopOutIsSt;
  assign memBypassFlags      = uopOutFlags;
  assign memBypassFlagsValid = dValid && uopOutFlagsValid;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage with a transaction-level reference model
// and a per-cycle output scoreboard.
module tb_memory_stage;

  localparam logic [3:0] EX_MIS = 4'd4;

  typedef struct packed {
    logic [3:0]  ex;
    logic        exValid;
    logic [4:0]  rd;
    logic [31:0] rdVal;
    logic [31:0] rs2Val;
    logic        isLd;
    logic        isSt;
    logic [1:0]  size;
    logic        isUnsigned;
    logic [3:0]  flags;
    logic        flagsValid;
  } tuop_t;

  typedef struct packed {
    logic [3:0]  ex;
    logic        exValid;
    logic [4:0]  rd;
    logic [31:0] rdVal;
    logic [3:0]  flags;
    logic        flagsValid;
    logic        isSt;
  } tout_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uValid = 1'b0;
  logic        uStall;
  logic        dValid;
  logic        dStall = 1'b0;
  logic [3:0]  uopInEx = '0;
  logic        uopInExValid = 1'b0;
  logic [4:0]  uopInRd = '0;
  logic [31:0] uopInRdVal = '0;
  logic [31:0] uopInRs2Val = '0;
  logic        uopInIsLd = 1'b0;
  logic        uopInIsSt = 1'b0;
  logic [1:0]  uopInSize = '0;
  logic        uopInIsUnsigned = 1'b0;
  logic [3:0]  uopInFlags = '0;
  logic        uopInFlagsValid = 1'b0;
  logic [3:0]  uopOutEx;
  logic        uopOutExValid;
  logic [4:0]  uopOutRd;
  logic [31:0] uopOutRdVal;
  logic [3:0]  uopOutFlags;
  logic        uopOutFlagsValid;
  logic        uopOutIsSt;
  logic [4:0]  memBypassR;
  logic [31:0] memBypassRVal;
  logic        memBypassRValid;
  logic [3:0]  memBypassFlags;
  logic        memBypassFlagsValid;
  logic        dmemReqValid;
  logic        dmemReqReady = 1'b0;
  logic [31:0] dmemReqAddr;
  logic        dmemReqWe;
  logic [3:0]  dmemReqWstrb;
  logic [31:0] dmemReqWdata;
  logic        dmemRspValid = 1'b0;
  logic [31:0] dmemRspData = '0;

  int    checks = 0;
  int    failures = 0;
  tout_t sb[$];
  logic  stallRandom = 1'b0;
  logic  stallForce = 1'b0;

  memory_stage dut (
    .clk(clk), .rst(rst), .uValid(uValid), .uStall(uStall), .dValid(dValid), .dStall(dStall),
    .uopInEx(uopInEx), .uopInExValid(uopInExValid), .uopInRd(uopInRd),
    .uopInRdVal(uopInRdVal), .uopInRs2Val(uopInRs2Val), .uopInIsLd(uopInIsLd),
    .uopInIsSt(uopInIsSt), .uopInSize(uopInSize), .uopInIsUnsigned(uopInIsUnsigned),
    .uopInFlags(uopInFlags), .uopInFlagsValid(uopInFlagsValid),
    .uopOutEx(uopOutEx), .uopOutExValid(uopOutExValid), .uopOutRd(uopOutRd),
    .uopOutRdVal(uopOutRdVal), .uopOutFlags(uopOutFlags), .uopOutFlagsValid(uopOutFlagsValid),
    .uopOutIsSt(uopOutIsSt), .memBypassR(memBypassR), .memBypassRVal(memBypassRVal),
    .memBypassRValid(memBypassRValid), .memBypassFlags(memBypassFlags),
    .memBypassFlagsValid(memBypassFlagsValid), .dmemReqValid(dmemReqValid),
    .dmemReqReady(dmemReqReady), .dmemReqAddr(dmemReqAddr), .dmemReqWe(dmemReqWe),
    .dmemReqWstrb(dmemReqWstrb), .dmemReqWdata(dmemReqWdata), .dmemRspValid(dmemRspValid),
    .dmemRspData(dmemRspData)
  );

  initial forever #5 clk = ~clk;

  task automatic finishBench();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what the stage must produce for one uop, from the architectural rules.
  function automatic logic modelMisaligned(input tuop_t u);
    int a;
    a = int'(u.rdVal % 4);
    if (u.size == 2'd1) return (a % 2) == 1;
    if (u.size == 2'd2) return a != 0;
    return 1'b0;
  endfunction

  function automatic logic modelNeedsReq(input tuop_t u);
    return (u.isLd || u.isSt) && !u.exValid && !modelMisaligned(u);
  endfunction

  function automatic logic [3:0] modelStrb(input tuop_t u);
    int a;
    a = int'(u.rdVal % 4);
    if (u.size == 2'd0) return 4'(1 << a);
    if (u.size == 2'd1) return 4'(3 << a);
    return 4'hF;
  endfunction

  function automatic logic [31:0] modelWdata(input tuop_t u);
    if (u.size == 2'd0) return (u.rs2Val % 256) * 32'h0101_0101;
    if (u.size == 2'd1) return (u.rs2Val % 65536) * 32'h0001_0001;
    return u.rs2Val;
  endfunction

  function automatic tout_t modelOut(input tuop_t u, input logic [31:0] rsp);
    tout_t       o;
    logic [31:0] lane;
    logic [31:0] v;
    o.ex = u.ex;  o.exValid = u.exValid;  o.rd = u.rd;  o.rdVal = u.rdVal;
    o.flags = u.flags;  o.flagsValid = u.flagsValid;  o.isSt = u.isSt;
    if ((u.isLd || u.isSt) && !u.exValid) begin
      if (modelMisaligned(u)) begin
        o.exValid = 1'b1;
        o.ex      = EX_MIS;
      end else if (u.isLd) begin
        lane = rsp >> (8 * (u.rdVal % 4));
        if (u.size == 2'd0) begin
          v = lane % 256;
          if (!u.isUnsigned && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (u.size == 2'd1) begin
          v = lane % 65536;
          if (!u.isUnsigned && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
          v = lane;
        end
        o.rdVal = v;
      end
    end
    return o;
  endfunction

  function automatic tuop_t mkUop(input logic ld, input logic st, input logic [1:0] size,
                                  input logic uns, input logic [4:0] rd,
                                  input logic [31:0] rdVal, input logic [31:0] rs2Val);
    tuop_t u;
    u = '0;
    u.isLd = ld;  u.isSt = st;  u.size = size;  u.isUnsigned = uns;
    u.rd = rd;  u.rdVal = rdVal;  u.rs2Val = rs2Val;
    u.flags = 4'hA;  u.flagsValid = 1'b1;
    return u;
  endfunction

  function automatic tuop_t randUop();
    tuop_t u;
    int    kind;
    kind         = $urandom_range(0, 9);
    u.ex         = 4'($urandom);
    u.exValid    = ($urandom_range(0, 9) == 0);
    u.rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    u.rdVal      = $urandom;
    u.rs2Val     = $urandom;
    u.isLd       = (kind >= 4 && kind <= 6);
    u.isSt       = (kind >= 7);
    u.size       = 2'($urandom_range(0, 2));
    u.isUnsigned = 1'($urandom);
    u.flags      = 4'($urandom);
    u.flagsValid = 1'($urandom);
    if ($urandom_range(0, 1) == 0) u.rdVal[1:0] = 2'b00;
    return u;
  endfunction

  task automatic driveUop(input tuop_t u);
    {uopInEx, uopInExValid, uopInRd, uopInRdVal, uopInRs2Val, uopInIsLd, uopInIsSt,
     uopInSize, uopInIsUnsigned, uopInFlags, uopInFlagsValid} = u;
  endtask

  task automatic junkRsp();
    dmemRspValid = 1'($urandom);
    dmemRspData  = $urandom;
  endtask

  task automatic setStall(input logic v);
    stallForce = v;
    dStall     = v;
  endtask

  task automatic checkReq(input string tag, input logic req, input tuop_t u);
    check({tag, "Valid"}, 64'(dmemReqValid), 64'(req));
    if (req) begin
      check({tag, "Addr"}, 64'(dmemReqAddr), 64'(u.rdVal & 32'hFFFF_FFFC));
      check({tag, "We"}, 64'(dmemReqWe), 64'(u.isSt));
      if (u.isSt)
        check({tag, "StrbData"}, 64'({dmemReqWstrb, dmemReqWdata}),
              64'({modelStrb(u), modelWdata(u)}));
    end
  endtask

  // Called just after a rising edge; returns just after the edge where the uop retires.
  task automatic applyStimulus(input tuop_t u, input int readyDelay, input int rspDelay,
                               input logic [31:0] rspData);
    tout_t exp;
    logic  req;
    int    waited;
    exp    = modelOut(u, rspData);
    req    = modelNeedsReq(u);
    waited = 0;
    driveUop(u);
    uValid       = 1'b1;
    dmemReqReady = (readyDelay == 0);
    junkRsp();
    forever begin
      @(negedge clk);
      check("uStallIdle", 64'(uStall), 64'(sb.size() != 0 && dStall));
      if (!uStall) break;
      waited++;
      if (waited > 50) begin
        checks++;
        failures++;
        $display("[TB] FAIL acceptTimeout actual=stalled expected=accept");
        finishBench();
      end
      @(posedge clk); #1;
      junkRsp();
    end
    checkReq("acceptReq", req, u);
    @(posedge clk); #1;
    uValid = 1'b0;
    driveUop(randUop());
    dmemRspValid = 1'b0;
    if (!req) begin
      dmemReqReady = 1'b0;
      sb.push_back(exp);
      return;
    end
    for (int i = 1; i <= readyDelay; i++) begin
      dmemReqReady = (i == readyDelay);
      junkRsp();
      @(negedge clk);
      check("uStallReq", 64'(uStall), 64'(1));
      checkReq("heldReq", 1'b1, u);
      @(posedge clk); #1;
    end
    dmemReqReady = 1'b0;
    dmemRspValid = 1'b0;
    if (!u.isLd) begin
      sb.push_back(exp);
      return;
    end
    for (int j = 0; j <= rspDelay; j++) begin
      dmemRspValid = (j == rspDelay);
      dmemRspData  = (j == rspDelay) ? rspData : $urandom;
      @(negedge clk);
      check("uStallWait", 64'(uStall), 64'(1));
      check("reqInWait", 64'(dmemReqValid), 64'(0));
      @(posedge clk); #1;
    end
    dmemRspValid = 1'b0;
    sb.push_back(exp);
  endtask

  // Output scoreboard: every cycle the MEM/WB register must show the oldest unconsumed result.
  task automatic checkOutput();
    tout_t exp;
    if (sb.size() == 0) begin
      check("idleOut", 64'({dValid, memBypassRValid, memBypassFlagsValid}), 64'(0));
    end else begin
      exp = sb[0];
      check("outValid", 64'(dValid), 64'(1));
      check("outUop", 64'({uopOutEx, uopOutExValid, uopOutRd, uopOutRdVal, uopOutFlags,
                           uopOutFlagsValid, uopOutIsSt}), 64'(exp));
      check("bypass", 64'({memBypassR, memBypassRVal, memBypassRValid, memBypassFlags,
                           memBypassFlagsValid}),
            64'({exp.rd, exp.rdVal, (exp.rd != 5'd0) && !exp.exValid && !exp.isSt,
                 exp.flags, exp.flagsValid}));
      if (dValid && !dStall) void'(sb.pop_front());
    end
  endtask

  initial forever begin
    @(negedge clk);
    checkOutput();
  end

  initial forever begin
    @(posedge clk); #1;
    dStall = stallRandom ? ($urandom_range(0, 2) == 0) : stallForce;
  end

  initial begin
    #400000;
    checks++;
    failures++;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    finishBench();
  end

  initial begin
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rstCtrl", 64'({dValid, dmemReqValid, memBypassRValid, memBypassFlagsValid, uStall}), 64'(0));
      check("rstUop", 64'({uopOutEx, uopOutExValid, uopOutRd, uopOutRdVal, uopOutFlags,
                           uopOutFlagsValid, uopOutIsSt}), 64'(0));
    end
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] ALU uops and bypass");
    applyStimulus(mkUop(0, 0, 2'd0, 0, 5'd5, 32'h1234, 32'h0), 0, 0, 32'h0);
    @(negedge clk);
    check("aluValid", 64'(dValid), 64'(1));
    check("aluBypass", 64'({memBypassR, memBypassRVal, memBypassRValid}), 64'({5'd5, 32'h1234, 1'b1}));
    @(posedge clk); #1;
    applyStimulus(mkUop(0, 0, 2'd0, 0, 5'd0, 32'h55, 32'h0), 0, 0, 32'h0);
    @(negedge clk);
    check("aluRd0RValid", 64'(memBypassRValid), 64'(0));
    @(posedge clk); #1;

    $display("[TB] store byte");
    fork
      applyStimulus(mkUop(0, 1, 2'd0, 0, 5'd3, 32'h1003, 32'hAB), 0, 0, 32'h0);
      begin
        @(negedge clk);
        check("stReqLit", 64'({dmemReqValid, dmemReqWe, dmemReqWstrb, dmemReqAddr}),
              64'({1'b1, 1'b1, 4'b1000, 32'h1000}));
        check("stDataLit", 64'(dmemReqWdata), 64'(32'hABAB_ABAB));
      end
    join
    @(negedge clk);
    check("stLatency", 64'({dValid, memBypassRValid}), 64'({1'b1, 1'b0}));
    @(posedge clk); #1;

    $display("[TB] loads");
    applyStimulus(mkUop(1, 0, 2'd0, 0, 5'd6, 32'h2001, 32'h0), 2, 3, 32'h0000_8000);
    @(negedge clk);
    check("ldSByte", 64'(uopOutRdVal), 64'(32'hFFFF_FF80));
    @(posedge clk); #1;
    applyStimulus(mkUop(1, 0, 2'd1, 1, 5'd7, 32'h2002, 32'h0), 0, 0, 32'hBEEF_0000);
    @(negedge clk);
    check("ldUHalf", 64'(uopOutRdVal), 64'(32'h0000_BEEF));
    @(posedge clk); #1;
    applyStimulus(mkUop(1, 0, 2'd2, 0, 5'd8, 32'h2002, 32'h0), 0, 0, 32'h0);
    @(negedge clk);
    check("ldMisaligned", 64'({uopOutExValid, uopOutEx, memBypassRValid}), 64'({1'b1, EX_MIS, 1'b0}));
    @(posedge clk); #1;

    $display("[TB] downstream stall");
    applyStimulus(mkUop(0, 0, 2'd0, 0, 5'd7, 32'h1111, 32'h0), 0, 0, 32'h0);
    setStall(1'b1);
    fork
      begin
        applyStimulus(mkUop(0, 0, 2'd0, 0, 5'd8, 32'h2222, 32'h0), 0, 0, 32'h0);
        applyStimulus(mkUop(0, 0, 2'd0, 0, 5'd9, 32'h3333, 32'h0), 0, 0, 32'h0);
      end
      begin
        repeat (2) begin
          @(negedge clk);
          check("stallHold", 64'({dValid, uStall, uopOutRdVal}), 64'({1'b1, 1'b1, 32'h1111}));
        end
        @(posedge clk); #1;
        setStall(1'b0);
      end
    join
    @(negedge clk);
    check("stallLast", 64'({dValid, uopOutRd, uopOutRdVal}), 64'({1'b1, 5'd9, 32'h3333}));
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset during WAIT");
    driveUop(mkUop(1, 0, 2'd2, 0, 5'd4, 32'h3000, 32'h0));
    uValid       = 1'b1;
    dmemReqReady = 1'b1;
    @(posedge clk); #1;
    uValid       = 1'b0;
    dmemReqReady = 1'b0;
    @(negedge clk);
    check("waitStall", 64'(uStall), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("midReset", 64'({uStall, dValid, dmemReqValid}), 64'(0));
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    dmemRspValid = 1'b1;
    dmemRspData  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmemRspValid = 1'b0;
    @(negedge clk);
    check("lateRspIgnored", 64'({dValid, uStall}), 64'(0));
    @(posedge clk); #1;
    applyStimulus(mkUop(0, 0, 2'd0, 0, 5'd10, 32'h4242, 32'h0), 0, 0, 32'h0);
    @(negedge clk);
    check("postReset", 64'({dValid, memBypassR, memBypassRVal}), 64'({1'b1, 5'd10, 32'h4242}));
    @(posedge clk); #1;

    $display("[TB] random traffic");
    stallRandom = 1'b1;
    for (int n = 0; n < 300; n++)
      applyStimulus(randUop(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    stallRandom = 1'b0;
    setStall(1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("sbDrained", 64'(sb.size()), 64'(0));
    finishBench();
  end

endmodule
